vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Arbitrates a single-port synchronous framebuffer RAM between three requesters:
  - the VGA scan-out read path, which is real-time;
  - a buffered pixel-write port for CPU or drawing logic;
  - a built-in full-screen clear engine.
- Sits between the 640x480 timing generator (supplies pixel address and consumes read data) and the framebuffer RAM.
- The display always wins. Clear and queued writes use the leftover cycles, mainly blanking.

Parameters:
- AW, 17, RAM address width.
- DW, 12, pixel width (RGB444).
- DEPTH, 76800, number of framebuffer words; the clear engine covers addresses 0..DEPTH-1.
- FIFO_DEPTH, 4, write FIFO entries (power of two).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- disp_req  in  1  display read request this cycle.
- disp_addr  in  AW  display read address.
- disp_data  out  DW  display read data, registered.
- disp_valid  out  1  disp_data valid.
- wr_valid  in  1  write request.
- wr_ready  out  1  write FIFO not full.
- wr_addr  in  AW  write address.
- wr_data  in  DW  write data.
- clr_start  in  1  one-cycle pulse that starts a clear.
- clr_color  in  DW  fill value, latched on clr_start.
- clr_busy  out  1  clear in progress.
- vblank  in  1  vertical blanking indicator; used only with the optional feature.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data, valid 1 cycle after a read enable.

Behaviour:
- Reset values:
  - disp_data=0, disp_valid=0, clr_busy=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - FIFO empty, so wr_ready=1.
  - FSM in IDLE, clear counter=0.
- Registered RAM outputs: mem_* are driven from registers. The grant decided in cycle N appears on mem_* in cycle N+1.
- Grant priority, evaluated each cycle:
  - Priority 1: disp_req — read disp_addr.
  - Priority 2: FSM in CLEAR — write clr_color at clr_addr.
  - Priority 3: FIFO non-empty — write head entry, then pop.
  - Otherwise mem_en=0.
  - mem_we is never 1 in a cycle granted to the display.
- Display latency: disp_req in cycle N gives disp_valid=1 in cycle N+2, with disp_data = RAM contents. disp_valid is a 2-stage delay of disp_req. Back-to-back requests give back-to-back data.
- Write FIFO:
  - Push on wr_valid && wr_ready; wr_ready = !full.
  - Pop only when granted.
  - Push and pop in the same cycle is allowed; occupancy is unchanged.
  - Minimum latency: accepted in cycle N, mem_we asserted in cycle N+2.
  - Writes reach RAM in acceptance order.
- Clear FSM, states IDLE and CLEAR:
  - IDLE to CLEAR on clr_start: latch clr_color, clr_addr=0, clr_busy=1 from the next cycle.
  - In CLEAR, clr_addr increments only on cycles the clear engine is granted.
  - After the grant for address DEPTH-1, return to IDLE; clr_busy falls the following cycle.
  - clr_start while in CLEAR is ignored (no restart).
  - The FIFO keeps accepting writes during CLEAR but is not drained until CLEAR ends. Writes queued before or during a clear therefore land after it and overwrite it.
- Reset mid-operation: clear aborted, FIFO contents discarded, no further RAM writes.
- Width rules:
  - clr_addr is AW bits; DEPTH must be ≤ 2^AW.
  - disp_addr is passed through unchecked; out-of-range addresses are the caller's responsibility.

Optional Feature:
- Macro VBLANK_ONLY_WR_EN.
- Defined: clear and FIFO grants are issued only while vblank=1, which prevents tearing. Display priority is unchanged. With vblank=0 the FIFO only fills, and wr_ready drops when it is full.
- Undefined: vblank is ignored, and writes use any non-display cycle.

Test Plan:
- Reset asserted mid-traffic -> next cycle: disp_valid=0, mem_en=0, mem_we=0, wr_ready=1, clr_busy=0; nothing already in the FIFO is written.
- Write addr 5 / 0xABC with disp_req=0; 4 cycles later disp_req addr 5 for 1 cycle -> mem_we=1 at addr 5 two cycles after accept; disp_valid=1 with disp_data=0xABC exactly 2 cycles after disp_req.
- disp_req held 12 cycles while wr_valid offers 6 writes -> exactly 4 accepted, then wr_ready=0; mem_we=0 during the whole disp_req window; after disp_req falls, 4 consecutive write cycles in order.
- DEPTH=16, clr_start with color 0x0F0, no display traffic -> clr_busy high exactly 17 cycles; mem_we addresses 0..15 with data 0x0F0; reading all 16 addresses returns 0x0F0.
- DEPTH=16, one write (addr 3, 0x123) queued just before clr_start, then clr_start while busy -> single clear of 16 addresses, no restart; then addr 3 written with 0x123; readback addr 3 = 0x123, all other addresses = clear color.
- VBLANK_ONLY_WR_EN defined, vblank=0, 2 writes pushed -> no mem_we; raise vblank -> both written on the next 2 cycles.

Source files
------------

// File: rtl/vram_arbiter.sv
// Framebuffer RAM arbiter: display reads first, then the clear engine, then queued pixel writes.
// Define VBLANK_ONLY_WR_EN to restrict clear and FIFO writes to vertical blanking.
module vram_arbiter #(
  parameter int AW         = 17,
  parameter int DW         = 12,
  parameter int DEPTH      = 76800,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          disp_req_i,
  input  logic [AW-1:0] disp_addr_i,
  output logic [DW-1:0] disp_data_o,
  output logic          disp_valid_o,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          clr_start_i,
  input  logic [DW-1:0] clr_color_i,
  output logic          clr_busy_o,
  input  logic          vblank_i,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] CLR_LAST = AW'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_CLR  = 2'd2,
    GNT_FIFO = 2'd3
  } grant_e;

  state_e        state_q, state_d;
  logic [AW-1:0] clr_addr_q, clr_addr_d;
  logic [DW-1:0] clr_color_q, clr_color_d;
  logic          clr_busy_q, clr_busy_d;

  logic [AW-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DW-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW:0]   wptr_q, wptr_d;
  logic [PW:0]   rptr_q, rptr_d;

  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]    disp_vld_q;

  grant_e        grant_s;
  logic          bg_ok_s;
  logic          fifo_empty_s;
  logic          fifo_full_s;
  logic          push_s;
  logic          pop_s;

`ifdef VBLANK_ONLY_WR_EN
  assign bg_ok_s = vblank_i;
`else
  logic unused_vblank_s;
  assign unused_vblank_s = vblank_i;
  assign bg_ok_s         = 1'b1;
`endif

  assign fifo_empty_s = (wptr_q == rptr_q);
  assign fifo_full_s  = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign push_s       = wr_valid_i && !fifo_full_s;
  assign pop_s        = (grant_s == GNT_FIFO);

  // Fixed-priority grant; the FIFO is held off for the start cycle too, so
  // writes queued before a clear always land after it.
  always_comb begin
    grant_s = GNT_NONE;
    if (disp_req_i) begin
      grant_s = GNT_DISP;
    end else if ((state_q == ST_CLEAR) && bg_ok_s) begin
      grant_s = GNT_CLR;
    end else if ((state_q == ST_IDLE) && !clr_start_i && !fifo_empty_s && bg_ok_s) begin
      grant_s = GNT_FIFO;
    end else begin
      grant_s = GNT_NONE;
    end
  end

  // Clear FSM next state
  always_comb begin
    state_d     = state_q;
    clr_addr_d  = clr_addr_q;
    clr_color_d = clr_color_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start_i) begin
          state_d     = ST_CLEAR;
          clr_addr_d  = {AW{1'b0}};
          clr_color_d = clr_color_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (grant_s == GNT_CLR) begin
          if (clr_addr_q == CLR_LAST) begin
            state_d    = ST_IDLE;
            clr_addr_d = {AW{1'b0}};
          end else begin
            clr_addr_d = clr_addr_q + AW'(1);
          end
        end else begin
          state_d = ST_CLEAR;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        clr_addr_d = {AW{1'b0}};
      end
    endcase
    // busy lags the state by one cycle so it stays up through the final clear write
    clr_busy_d = (state_q == ST_CLEAR) || ((state_q == ST_IDLE) && clr_start_i);
  end

  // FIFO pointer update
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_s) begin
      wptr_d = wptr_q + {{PW{1'b0}}, 1'b1};
    end else begin
      wptr_d = wptr_q;
    end
    if (pop_s) begin
      rptr_d = rptr_q + {{PW{1'b0}}, 1'b1};
    end else begin
      rptr_d = rptr_q;
    end
  end

  // RAM command for next cycle
  always_comb begin
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (grant_s)
      GNT_DISP: begin
        mem_en_d   = 1'b1;
        mem_addr_d = disp_addr_i;
      end
      GNT_CLR: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = clr_addr_q;
        mem_wdata_d = clr_color_q;
      end
      GNT_FIFO: begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = fifo_addr_q[rptr_q[PW-1:0]];
        mem_wdata_d = fifo_data_q[rptr_q[PW-1:0]];
      end
      default: begin
        mem_en_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  // Control and pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      clr_addr_q  <= {AW{1'b0}};
      clr_color_q <= {DW{1'b0}};
      clr_busy_q  <= 1'b0;
      wptr_q      <= {(PW+1){1'b0}};
      rptr_q      <= {(PW+1){1'b0}};
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= {DW{1'b0}};
      disp_vld_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      clr_addr_q  <= clr_addr_d;
      clr_color_q <= clr_color_d;
      clr_busy_q  <= clr_busy_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      disp_vld_q  <= {disp_vld_q[0], disp_req_i};
    end
  end

  // Write FIFO storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= {AW{1'b0}};
        fifo_data_q[i] <= {DW{1'b0}};
      end
    end else if (push_s) begin
      fifo_addr_q[wptr_q[PW-1:0]] <= wr_addr_i;
      fifo_data_q[wptr_q[PW-1:0]] <= wr_data_i;
    end
  end

  // RAM output is itself registered; gating keeps disp_data at zero outside valid beats
  assign disp_data_o  = disp_vld_q[1] ? mem_rdata_i : {DW{1'b0}};
  assign disp_valid_o = disp_vld_q[1];
  assign wr_ready_o   = !fifo_full_s;
  assign clr_busy_o   = clr_busy_q;
  assign mem_en_o     = mem_en_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
